// File: rtl/rx_regfile.sv
// 8N1 UART receiver + packet assembler: NUM_BYTES bytes, byte k into reg_file[8k+7:8k]; valid pulses 2 clk12 after the final stop sample, no backpressure.
// Optional `define RX_TIMEOUT_EN adds an idle timeout (TIMEOUT_CLKS) that aborts a stalled partial packet.
module rx_regfile #(
   parameter int CLKS_PER_BIT = 104,
   parameter int NUM_BYTES    = 128,
   parameter int TIMEOUT_CLKS = 20000
) (
   input  logic                   clk12,
   input  logic                   rstn,
   input  logic                   rx,
   output logic [8*NUM_BYTES-1:0] reg_file,
   output logic                   valid,
   output logic                   busy,
   output logic                   frame_err,
   output logic [6:0]             byte_count
);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int ADDR_W = $clog2(8*NUM_BYTES);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [6:0]       LAST_BYTE = 7'(NUM_BYTES - 1);

   if (NUM_BYTES < 1 || NUM_BYTES > 128) begin : g_bad_num_bytes
      $error("rx_regfile: NUM_BYTES must be in 1..128");
   end
   if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_bad_timing
      $error("rx_regfile: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic                   rx_m;
   logic                   rx_s;
   logic                   rx_prev;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift;
   logic [8*NUM_BYTES-1:0] shadow;
   logic                   commit;
   logic                   start_edge;
   logic [ADDR_W-1:0]      wr_base;

`ifdef RX_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
   logic [IDLE_W-1:0] idle_cnt;
`endif

   assign start_edge = rx_prev & ~rx_s;
   assign wr_base    = ADDR_W'({byte_count, 3'b000});

   // rx is asynchronous to clk12; flops reset high to match the idle line.
   always_ff @(posedge clk12) begin
      if (!rstn) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk12) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         shadow     <= '0;
         reg_file   <= '0;
         commit     <= 1'b0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         byte_count <= '0;
`ifdef RX_TIMEOUT_EN
         idle_cnt   <= '0;
`endif
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         commit    <= 1'b0;

         // Shadow already holds the final byte when commit is seen.
         if (commit) begin
            reg_file <= shadow;
            valid    <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_edge) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (rx_s) begin
                     shadow[wr_base +: 8] <= shift;
                     if (byte_count == LAST_BYTE) begin
                        commit     <= 1'b1;
                        byte_count <= '0;
                        busy       <= 1'b0;
                     end else begin
                        byte_count <= byte_count + 1'b1;
                        busy       <= 1'b1;
                     end
                  end else begin
                     frame_err  <= 1'b1;
                     byte_count <= '0;
                     busy       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef RX_TIMEOUT_EN
         // Only counts the gap between bytes; any start edge re-arms it.
         if (start_edge || !busy) begin
            idle_cnt <= '0;
         end else if (state == IDLE) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1)) begin
               idle_cnt   <= '0;
               byte_count <= '0;
               busy       <= 1'b0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_rx_regfile.sv
// Scoreboard bench for rx_regfile: stimulus queues expected images/pulse times, a monitor checks them on valid/frame_err.
module tb_rx_regfile;
   localparam int CPB  = 10;
   localparam int NB   = 128;
   localparam int TO   = 5000;
   localparam int HALF = CPB / 2;
   localparam int W    = 8 * NB;

   logic         clk12 = 1'b0;
   logic         rstn  = 1'b0;
   logic         rx    = 1'b1;
   logic [W-1:0] reg_file;
   logic         valid;
   logic         busy;
   logic         frame_err;
   logic [6:0]   byte_count;

   rx_regfile #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .TIMEOUT_CLKS(TO)) dut (
      .clk12      (clk12),
      .rstn       (rstn),
      .rx         (rx),
      .reg_file   (reg_file),
      .valid      (valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .byte_count (byte_count)
   );

   always #5 clk12 = ~clk12;

   int cyc = 0;
   always @(posedge clk12) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] img;
      int           at;
   } vexp_t;

   vexp_t        vq[$];
   int           fq[$];
   int           checks = 0;
   int           errors = 0;
   int           stab_prints = 0;
   logic [W-1:0] model = '0;
   bit           rst_pending = 1'b0;

   // Monitor: pops expectations on DUT pulses, and checks reg_file never moves otherwise.
   initial begin : monitor
      forever begin
         @(negedge clk12);
         if (rst_pending) model = '0;
         rst_pending = !rstn;
         if (valid === 1'b1) begin
            checks++;
            if (vq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid at cycle %0d: got pulse, want none", cyc);
            end else begin
               vexp_t e;
               e = vq.pop_front();
               model = e.img;
               checks++;
               if (reg_file !== e.img) begin
                  errors++;
                  $display("FAIL valid_image: got lo=%h hi=%h want lo=%h hi=%h",
                           reg_file[63:0], reg_file[W-1:W-64], e.img[63:0], e.img[W-1:W-64]);
               end
               checks++;
               if (cyc < e.at - 1 || cyc > e.at + 1) begin
                  errors++;
                  $display("FAIL valid_latency: got cycle %0d want %0d +-1", cyc, e.at);
               end
            end
         end
         if (frame_err === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_err at cycle %0d: got pulse, want none", cyc);
            end else begin
               int at;
               at = fq.pop_front();
               checks++;
               if (cyc < at - 1 || cyc > at + 1) begin
                  errors++;
                  $display("FAIL frame_err_time: got cycle %0d want %0d +-1", cyc, at);
               end
            end
         end
         checks++;
         if (reg_file !== model) begin
            errors++;
            if (stab_prints < 5) begin
               stab_prints++;
               $display("FAIL reg_file_stable at cycle %0d: got lo=%h want lo=%h",
                        cyc, reg_file[63:0], model[63:0]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk12);
      #1;
   endtask

   // Called one step after a posedge; expected pulse cycles follow from sync (2) + edge detect + mid-bit sampling.
   task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit last, input logic [W-1:0] img);
      if (last) begin
         vexp_t e;
         e.img = img;
         e.at  = cyc + 4 + HALF + 9 * CPB;
         vq.push_back(e);
      end
      if (!stop_ok) fq.push_back(cyc + 3 + HALF + 9 * CPB);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = stop_ok;
      tick(CPB);
      rx = 1'b1;
   endtask

   task automatic send_packet(input logic [W-1:0] img, input int nbytes);
      for (int k = 0; k < nbytes; k++) begin
         send_byte(img[8*k +: 8], 1'b1, (k == NB - 1), img);
      end
   endtask

   task automatic check_state(input string name, input logic [6:0] bc, input logic bz);
      checks++;
      if (byte_count !== bc) begin
         errors++;
         $display("FAIL %s byte_count: got %0d want %0d", name, byte_count, bc);
      end
      checks++;
      if (busy !== bz) begin
         errors++;
         $display("FAIL %s busy: got %b want %b", name, busy, bz);
      end
   endtask

   initial begin : stim
      logic [W-1:0] img;
      rx   = 1'b1;
      rstn = 1'b0;
      tick(3);
      rstn = 1'b1;
      tick(5);
      check_state("reset", 7'd0, 1'b0);
      checks++;
      if (reg_file !== '0 || valid !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got reg_lo=%h valid=%b frame_err=%b want 0 0 0",
                  reg_file[63:0], valid, frame_err);
      end

      // Incrementing packet 0x00..0x7F, back-to-back.
      for (int k = 0; k < NB; k++) img[8*k +: 8] = 8'(k);
      send_packet(img, NB);
      tick(20);
      check_state("inc_after", 7'd0, 1'b0);

      // Five bytes then a framing error discards the partial packet.
      for (int k = 0; k < 5; k++) send_byte(8'h3C, 1'b1, 1'b0, '0);
      tick(3);
      check_state("err_before", 7'd5, 1'b1);
      send_byte(8'hA5, 1'b0, 1'b0, '0);
      tick(20);
      check_state("err_after", 7'd0, 1'b0);
      img = '1;
      send_packet(img, NB);
      tick(20);
      check_state("ones_after", 7'd0, 1'b0);

      // Short low glitch while idle must be rejected at the start-bit re-sample.
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(40);
      check_state("glitch", 7'd0, 1'b0);

      // Reset in the middle of a packet.
      img = {NB{8'h5A}};
      send_packet(img, 64);
      tick(5);
      check_state("mid_packet", 7'd64, 1'b1);
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      tick(2);
      check_state("mid_reset", 7'd0, 1'b0);
      checks++;
      if (reg_file !== '0) begin
         errors++;
         $display("FAIL mid_reset_reg_file: got lo=%h want 0", reg_file[63:0]);
      end

      // Two consecutive packets; the monitor holds reg_file at 0x11 until the second valid.
      img = {NB{8'h11}};
      send_packet(img, NB);
      img = {NB{8'h22}};
      send_packet(img, NB);
      tick(20);
      check_state("two_pkts", 7'd0, 1'b0);

      // Stalled partial packet.
      for (int k = 0; k < 3; k++) send_byte(8'h77, 1'b1, 1'b0, '0);
      tick(6000);
`ifdef RX_TIMEOUT_EN
      check_state("timeout", 7'd0, 1'b0);
`else
      check_state("no_timeout", 7'd3, 1'b1);
`endif

      tick(5);
      checks++;
      if (vq.size() != 0) begin
         errors++;
         $display("FAIL missing_valid: got %0d unmatched, want 0", vq.size());
      end
      checks++;
      if (fq.size() != 0) begin
         errors++;
         $display("FAIL missing_frame_err: got %0d unmatched, want 0", fq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
